// File: rtl/ascii_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ascii_cmd_assembler
// Description : Keypad/terminal command assembler. Classifies received ASCII
//               bytes into keypad codes (0-9, A-D), clear ('*') and enter
//               ('#'). It accumulates up to DIGITS digit nibbles and presents
//               a finished command on a valid/ready handshake.
// Options     : CMD_TIMEOUT_EN - when defined, a partial entry that sees no
//               byte for TIMEOUT_CYC cycles is discarded and 'timeout' pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_cmd_assembler #(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [4*DIGITS-1:0]           cmd_value,
    output logic [$clog2(DIGITS+1)-1:0]   cmd_len,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
    output logic                          err,
    output logic                          timeout
);

    localparam int CW = $clog2(DIGITS+1);
    localparam int AW = 4*DIGITS;

    // IDLE: nothing entered, COLLECT: partial entry, HOLD: command on offer
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_shift;
    logic [AW-1:0] acc_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] value_nxt;
    logic [CW-1:0] len_nxt;
    logic          valid_nxt;
    logic          err_nxt;
    logic          tmo_nxt;

    logic          is_digit;
    logic          is_clear;
    logic          is_enter;
    logic [3:0]    nib;
    logic          full;
    logic          tmo_expire;

    // Byte classification: every class is decoded explicitly, unknown bytes
    // fall through with all class flags low and are rejected downstream.
    always_comb begin
        is_digit = 1'b0;
        is_clear = 1'b0;
        is_enter = 1'b0;
        nib      = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_digit = 1'b1;
            nib      = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h44) begin
            // 'A'..'D' have low nibbles 1..4; offset by 9 to reach 0xA..0xD
            is_digit = 1'b1;
            nib      = rx_data[3:0] + 4'd9;
        end else if (rx_data == 8'h2A) begin
            is_clear = 1'b1;
        end else if (rx_data == 8'h23) begin
            is_enter = 1'b1;
        end
    end

    assign full = (digit_cnt == CW'(DIGITS));

    // Shift the new nibble in at the bottom so the first digit ends up on top
    generate
        if (DIGITS > 1) begin : g_shift_multi
            assign acc_shift = {acc[AW-5:0], nib};
        end else begin : g_shift_single
            assign acc_shift = nib;
        end
    endgenerate

`ifdef CMD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tmo_cnt;

    // Entry expires only while collecting and only when no byte arrives now
    assign tmo_expire = (state == S_COLLECT) && !rx_valid &&
                        (tmo_cnt == TW'(TIMEOUT_CYC-1));

    // Idle-cycle counter: runs in COLLECT, restarts on any received byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != S_COLLECT || rx_valid || tmo_expire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    // The timeout length has no effect when the counter is not built
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo_expire         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (rx_valid) begin
                    if (is_digit && !full) begin
                        state_nxt = S_COLLECT;
                    end else if (is_clear) begin
                        state_nxt = S_IDLE;
                    end else if (is_enter && digit_cnt != '0) begin
                        state_nxt = S_HOLD;
                    end
                end else if (tmo_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cmd_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath decode: next values for every registered output
    always_comb begin
        acc_nxt   = acc;
        cnt_nxt   = digit_cnt;
        value_nxt = cmd_value;
        len_nxt   = cmd_len;
        valid_nxt = cmd_valid;
        err_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        if (!full) begin
                            acc_nxt = acc_shift;
                            cnt_nxt = digit_cnt + CW'(1);
                        end else begin
                            // Overflow digit: reject, keep what was entered
                            err_nxt = 1'b1;
                        end
                    end else if (is_clear) begin
                        acc_nxt = '0;
                        cnt_nxt = '0;
                    end else if (is_enter) begin
                        if (digit_cnt != '0) begin
                            value_nxt = acc;
                            len_nxt   = digit_cnt;
                            valid_nxt = 1'b1;
                            acc_nxt   = '0;
                            cnt_nxt   = '0;
                        end else begin
                            // Enter with nothing entered is meaningless
                            err_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (tmo_expire) begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    tmo_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // Command is frozen; anything arriving now is lost
                if (rx_valid) begin
                    err_nxt = 1'b1;
                end
                if (cmd_ready) begin
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            digit_cnt <= '0;
            cmd_value <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            digit_cnt <= cnt_nxt;
            cmd_value <= value_nxt;
            cmd_len   <= len_nxt;
            cmd_valid <= valid_nxt;
            err       <= err_nxt;
            timeout   <= tmo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascii_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascii_cmd_assembler
// Description : Scoreboard bench for ascii_cmd_assembler. Stimulus tasks push
//               the expected per-byte response and expected commands; an
//               independent monitor pops and compares as the DUT responds.
//               Timeout checks are built when CMD_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_cmd_assembler;

    localparam int DIGITS      = 4;
    localparam int CW          = $clog2(DIGITS+1);
    localparam int TIMEOUT_CYC = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic                 rx_valid = 1'b0;
    logic                 cmd_ready = 1'b0;
    logic [4*DIGITS-1:0]  cmd_value;
    logic [CW-1:0]        cmd_len;
    logic                 cmd_valid;
    logic [CW-1:0]        digit_cnt;
    logic                 err;
    logic                 timeout;

    ascii_cmd_assembler #(
        .DIGITS      (DIGITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_value (cmd_value),
        .cmd_len   (cmd_len),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .digit_cnt (digit_cnt),
        .err       (err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [CW-1:0] cnt;
        logic          vld;
    } resp_t;

    typedef struct {
        logic [4*DIGITS-1:0] value;
        logic [CW-1:0]       len;
    } cmd_t;

    resp_t resp_q[$];
    cmd_t  cmd_q[$];
    int    tmo_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic                rv_q = 1'b0;
    logic                hs_q = 1'b0;
    logic [4*DIGITS-1:0] val_q = '0;
    logic [CW-1:0]       len_q = '0;

    resp_t r_m;
    cmd_t  c_m;
    int    t_m;

    // Capture what the DUT sampled at this edge (pre-update output values)
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rv_q  <= rx_valid;
        hs_q  <= cmd_valid && cmd_ready;
        val_q <= cmd_value;
        len_q <= cmd_len;
    end

    // Monitor: compares DUT responses against the scoreboard queues
    always @(negedge clk) begin
        if (rv_q) begin
            vectors++;
            if (resp_q.size() == 0) begin
                miscompares++;
                $display("FAIL resp_underflow: got err=%b cnt=%0d vld=%b, no expectation queued",
                         err, digit_cnt, cmd_valid);
            end else begin
                r_m = resp_q.pop_front();
                if (err !== r_m.err || digit_cnt !== r_m.cnt ||
                    cmd_valid !== r_m.vld || timeout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL byte_resp @%0d: got err=%b cnt=%0d vld=%b tmo=%b, exp err=%b cnt=%0d vld=%b tmo=0",
                             cyc, err, digit_cnt, cmd_valid, timeout, r_m.err, r_m.cnt, r_m.vld);
                end
            end
        end else if (err !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_err @%0d: got err=%b, exp 0", cyc, err);
        end

        if (hs_q) begin
            vectors++;
            if (cmd_q.size() == 0) begin
                miscompares++;
                $display("FAIL cmd_underflow: got value=%h len=%0d, no command expected", val_q, len_q);
            end else begin
                c_m = cmd_q.pop_front();
                if (val_q !== c_m.value || len_q !== c_m.len) begin
                    miscompares++;
                    $display("FAIL cmd @%0d: got value=%h len=%0d, exp value=%h len=%0d",
                             cyc, val_q, len_q, c_m.value, c_m.len);
                end
            end
            vectors++;
            if (cmd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL valid_drop @%0d: got cmd_valid=%b, exp 0", cyc, cmd_valid);
            end
        end

        if (timeout !== 1'b0) begin
            vectors++;
            if (tmo_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_timeout @%0d: got timeout=%b, exp 0", cyc, timeout);
            end else begin
                t_m = tmo_q.pop_front();
                if (cyc != t_m || digit_cnt !== '0) begin
                    miscompares++;
                    $display("FAIL timeout_pulse: got cycle=%0d cnt=%0d, exp cycle=%0d cnt=0",
                             cyc, digit_cnt, t_m);
                end
            end
        end
    end

    // Strobe one byte (optionally with cmd_ready) and queue its expected response
    task automatic send(input logic [7:0] b, input logic rdy,
                        input logic e, input int c, input logic v);
        resp_t r;
        r.err = e;
        r.cnt = CW'(c);
        r.vld = v;
        resp_q.push_back(r);
        rx_data   = b;
        rx_valid  = 1'b1;
        cmd_ready = rdy;
        @(negedge clk);
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        rx_data   = 8'h00;
    endtask

    task automatic expect_cmd(input logic [4*DIGITS-1:0] v, input int l);
        cmd_t c;
        c.value = v;
        c.len   = CW'(l);
        cmd_q.push_back(c);
    endtask

    // Accept the pending command for one cycle
    task automatic accept(input logic [4*DIGITS-1:0] v, input int l);
        expect_cmd(v, l);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic ok, input string got);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %s, exp all zero", name, got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_state",
                  cmd_value === '0 && cmd_len === '0 && cmd_valid === 1'b0 &&
                  digit_cnt === '0 && err === 1'b0 && timeout === 1'b0,
                  $sformatf("value=%h len=%0d vld=%b cnt=%0d err=%b tmo=%b",
                            cmd_value, cmd_len, cmd_valid, digit_cnt, err, timeout));
        rst_n = 1'b1;
        @(negedge clk);

        // 1 2 A # -> 0x012A, len 3
        send(8'h31, 1'b0, 1'b0, 1, 1'b0);
        send(8'h32, 1'b0, 1'b0, 2, 1'b0);
        send(8'h41, 1'b0, 1'b0, 3, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        idle(2);
        accept(16'h012A, 3);

        // 1 2 3 4 5 # -> overflow err on 5, 0x1234 len 4
        send(8'h31, 1'b0, 1'b0, 1, 1'b0);
        send(8'h32, 1'b0, 1'b0, 2, 1'b0);
        send(8'h33, 1'b0, 1'b0, 3, 1'b0);
        send(8'h34, 1'b0, 1'b0, 4, 1'b0);
        send(8'h35, 1'b0, 1'b1, 4, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        accept(16'h1234, 4);

        // 7 * # -> cleared, then enter with nothing is an error
        send(8'h37, 1'b0, 1'b0, 1, 1'b0);
        send(8'h2A, 1'b0, 1'b0, 0, 1'b0);
        send(8'h23, 1'b0, 1'b1, 0, 1'b0);

        // Invalid bytes and class boundaries; '*' in IDLE is silent
        send(8'h78, 1'b0, 1'b1, 0, 1'b0);
        send(8'h61, 1'b0, 1'b1, 0, 1'b0);
        send(8'h45, 1'b0, 1'b1, 0, 1'b0);
        send(8'h2F, 1'b0, 1'b1, 0, 1'b0);
        send(8'h3A, 1'b0, 1'b1, 0, 1'b0);
        send(8'h40, 1'b0, 1'b1, 0, 1'b0);
        send(8'h2A, 1'b0, 1'b0, 0, 1'b0);

        // Range edges 0, 9, D -> 0x009D len 3; invalid mid-entry keeps count
        send(8'h30, 1'b0, 1'b0, 1, 1'b0);
        send(8'h39, 1'b0, 1'b0, 2, 1'b0);
        send(8'h7A, 1'b0, 1'b1, 2, 1'b0);
        send(8'h44, 1'b0, 1'b0, 3, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        accept(16'h009D, 3);

        // HOLD: bytes dropped, including the one coinciding with cmd_ready
        send(8'h42, 1'b0, 1'b0, 1, 1'b0);
        send(8'h43, 1'b0, 1'b0, 2, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        idle(10);
        send(8'h39, 1'b0, 1'b1, 0, 1'b1);
        expect_cmd(16'h00BC, 2);
        send(8'h33, 1'b1, 1'b1, 0, 1'b0);
        // Immediately after HOLD: back-to-back entry, earliest next command
        send(8'h38, 1'b0, 1'b0, 1, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        accept(16'h0008, 1);

        // Reset mid-entry
        send(8'h36, 1'b0, 1'b0, 1, 1'b0);
        send(8'h37, 1'b0, 1'b0, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_now("reset_mid_entry", digit_cnt === '0 && cmd_valid === 1'b0,
                     $sformatf("cnt=%0d vld=%b", digit_cnt, cmd_valid));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-HOLD: command discarded, accumulator clean afterwards
        send(8'h31, 1'b0, 1'b0, 1, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        idle(2);
        #2 rst_n = 1'b0;
        #1 check_now("reset_mid_hold",
                     cmd_valid === 1'b0 && cmd_value === '0 && cmd_len === '0,
                     $sformatf("vld=%b value=%h len=%0d", cmd_valid, cmd_value, cmd_len));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h23, 1'b0, 1'b1, 0, 1'b0);
        send(8'h34, 1'b0, 1'b0, 1, 1'b0);
        send(8'h23, 1'b0, 1'b0, 0, 1'b1);
        accept(16'h0004, 1);

`ifdef CMD_TIMEOUT_EN
        // Partial entry expires after TIMEOUT_CYC idle cycles
        send(8'h35, 1'b0, 1'b0, 1, 1'b0);
        tmo_q.push_back(cyc + TIMEOUT_CYC);
        idle(20);
        // A byte every 15 cycles keeps the entry alive
        send(8'h35, 1'b0, 1'b0, 1, 1'b0);
        repeat (4) begin
            idle(TIMEOUT_CYC - 2);
            send(8'h78, 1'b0, 1'b1, 1, 1'b0);
        end
        idle(TIMEOUT_CYC - 2);
        send(8'h2A, 1'b0, 1'b0, 0, 1'b0);
`else
        // Without the timeout a partial entry persists indefinitely
        send(8'h35, 1'b0, 1'b0, 1, 1'b0);
        idle(TIMEOUT_CYC + 4);
        send(8'h36, 1'b0, 1'b0, 2, 1'b0);
        send(8'h2A, 1'b0, 1'b0, 0, 1'b0);
`endif

        idle(3);
        check_now("resp_queue_drained", resp_q.size() == 0,
                  $sformatf("%0d pending responses", resp_q.size()));
        check_now("cmd_queue_drained", cmd_q.size() == 0,
                  $sformatf("%0d pending commands", cmd_q.size()));
        check_now("timeout_queue_drained", tmo_q.size() == 0,
                  $sformatf("%0d pending timeouts", tmo_q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
